// File: rtl/bist_pattern_driver.sv
// Exhaustive pattern driver with serial MISR response compaction for small CUTs.
// Optional run abort port enabled by defining BIST_ABORT_EN.
module bist_pattern_driver #(
    parameter int unsigned      WIDTH   = 2,
    parameter int unsigned      LATENCY = 1,
    parameter int unsigned      SIG_W   = 8,
    parameter logic [SIG_W-1:0] POLY    = SIG_W'('h1D)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
`ifdef BIST_ABORT_EN
    input  logic             abort,
`endif
    output logic [WIDTH-1:0] pat_out,
    input  logic             resp_in,
    output logic             busy,
    output logic             done,
    output logic [SIG_W-1:0] signature,
    output logic [WIDTH:0]   pat_count
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam int unsigned DW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] pat_q, pat_d;
    logic [DW-1:0]    drn_q, drn_d;
    logic [SIG_W-1:0] sig_q, sig_d;
    logic [WIDTH:0]   cnt_q, cnt_d;
    logic             run;
    logic             drain;
    logic             launch;
    logic             abort_hit;
    logic             vld_out;

    assign run    = (state_q == S_RUN);
    assign drain  = (state_q == S_DRAIN);
    assign launch = (state_q == S_IDLE) && start;

`ifdef BIST_ABORT_EN
    assign abort_hit = abort && (run || drain);
`else
    assign abort_hit = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        drn_d   = drn_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    pat_d   = '0;
                end
            end
            S_RUN: begin
                pat_d = pat_q + WIDTH'(1);
                drn_d = '0;
                if (&pat_q) begin
                    state_d = (LATENCY == 0) ? S_DONE : S_DRAIN;
                end
            end
            S_DRAIN: begin
                drn_d = drn_q + DW'(1);
                if (drn_q == DW'(LATENCY - 1)) begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (abort_hit) begin
            state_d = S_IDLE;
        end
    end

    // Responses arrive LATENCY cycles after their pattern; a valid bit rides along.
    if (LATENCY == 0) begin : g_comb
        assign vld_out = run;
    end else begin : g_dly
        logic [LATENCY-1:0] vld_q;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_q <= '0;
            end else if (abort_hit) begin
                vld_q <= '0;
            end else begin
                vld_q <= (vld_q << 1) | LATENCY'(run);
            end
        end
        assign vld_out = vld_q[LATENCY-1];
    end

    always_comb begin
        sig_d = sig_q;
        cnt_d = cnt_q;
        if (launch) begin
            sig_d = '0;
            cnt_d = '0;
        end else if (vld_out) begin
            sig_d = {sig_q[SIG_W-2:0], 1'b0}
                  ^ (sig_q[SIG_W-1] ? POLY : '0)
                  ^ SIG_W'(resp_in);
            cnt_d = cnt_q + (WIDTH+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pat_q   <= '0;
            drn_q   <= '0;
            sig_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            drn_q   <= drn_d;
            sig_q   <= sig_d;
            cnt_q   <= cnt_d;
        end
    end

    assign pat_out   = run ? pat_q : '0;
    assign busy      = run || drain;
    assign done      = (state_q == S_DONE);
    assign signature = sig_q;
    assign pat_count = cnt_q;

endmodule
